// File: rtl/m16_bit_pkg.sv
// rtl/m16_bit_pkg.sv - shared width, clamp constants and operand word type for the saturating adder
package m16_bit_pkg;

  localparam int DEF_WIDTH = 16;

  localparam logic [DEF_WIDTH-1:0] SAT_MAX = {1'b0, {(DEF_WIDTH-1){1'b1}}};
  localparam logic [DEF_WIDTH-1:0] SAT_MIN = {1'b1, {(DEF_WIDTH-1){1'b0}}};

  typedef logic signed [DEF_WIDTH-1:0] word_t;

endpackage

// File: rtl/m16_bit_sat_core.sv
// rtl/m16_bit_sat_core.sv - combinational two's-complement add with clamp to +max/-min
module m16_bit_sat_core
  import m16_bit_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             sat_pos,
  output logic             sat_neg
);

  localparam logic [WIDTH-1:0] MAX_V = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_V = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH:0] wide;

  assign wide = {a[WIDTH-1], a} + {b[WIDTH-1], b};

  // The extended sign disagrees with the WIDTH-bit sign only when both operands share a sign and the sum flipped it.
  assign sat_pos = ~wide[WIDTH] &  wide[WIDTH-1];
  assign sat_neg =  wide[WIDTH] & ~wide[WIDTH-1];

  assign sum = sat_pos ? MAX_V :
               sat_neg ? MIN_V : wide[WIDTH-1:0];

endmodule

// File: rtl/m16_bit_adder.sv
// rtl/m16_bit_adder.sv - registered saturating adder; M16_BIT_STICKY_OVF_EN adds a sticky overflow flag
module m16_bit_adder
  import m16_bit_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] add_out,
  output logic             out_valid,
  output logic             sat_pos,
  output logic             sat_neg
`ifdef M16_BIT_STICKY_OVF_EN
  ,
  input  logic             ovf_clr,
  output logic             ovf_sticky
`endif
);

  logic [WIDTH-1:0] sum_c;
  logic             pos_c;
  logic             neg_c;

  m16_bit_sat_core #(.WIDTH(WIDTH)) u_core (
    .a       (a),
    .b       (b),
    .sum     (sum_c),
    .sat_pos (pos_c),
    .sat_neg (neg_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      add_out   <= '0;
      out_valid <= 1'b0;
      sat_pos   <= 1'b0;
      sat_neg   <= 1'b0;
    end else begin
      out_valid <= in_valid;
      // Result and flags hold across idle cycles so add_out always describes the last accepted pair.
      if (in_valid) begin
        add_out <= sum_c;
        sat_pos <= pos_c;
        sat_neg <= neg_c;
      end
    end
  end

`ifdef M16_BIT_STICKY_OVF_EN
  // A saturation being registered this edge beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_sticky <= 1'b0;
    end else if (in_valid && (pos_c || neg_c)) begin
      ovf_sticky <= 1'b1;
    end else if (ovf_clr) begin
      ovf_sticky <= 1'b0;
    end
  end
`else
  // No sticky overflow tracking in this build.
`endif

endmodule

// File: tb/tb_m16_bit_adder.sv
// tb/tb_m16_bit_adder.sv - vector table, directed sequences and randomized model check of m16_bit_adder
module tb_m16_bit_adder;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] sum;
    logic        pos;
    logic        neg;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] a;
  logic [15:0] b;
  logic [15:0] add_out;
  logic        out_valid;
  logic        sat_pos;
  logic        sat_neg;
`ifdef M16_BIT_STICKY_OVF_EN
  logic        ovf_clr;
  logic        ovf_sticky;
  logic        m_sticky;
`endif

  int total;
  int bad;

  logic [15:0] m_sum;
  logic        m_valid;
  logic        m_pos;
  logic        m_neg;

  m16_bit_adder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .add_out   (add_out),
    .out_valid (out_valid),
    .sat_pos   (sat_pos),
    .sat_neg   (sat_neg)
`ifdef M16_BIT_STICKY_OVF_EN
    ,
    .ovf_clr   (ovf_clr),
    .ovf_sticky(ovf_sticky)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: exact integer sum, clamped to the signed 16-bit range.
  task automatic ref_add(input logic [15:0] x, input logic [15:0] y,
                         output logic [15:0] s, output logic p, output logic n);
    int r;
    r = int'($signed(x)) + int'($signed(y));
    p = 1'b0;
    n = 1'b0;
    if (r > 32767) begin
      s = 16'h7FFF;
      p = 1'b1;
    end else if (r < -32768) begin
      s = 16'h8000;
      n = 1'b1;
    end else begin
      s = r[15:0];
    end
  endtask

  task automatic model_reset();
    m_sum   = '0;
    m_valid = 1'b0;
    m_pos   = 1'b0;
    m_neg   = 1'b0;
`ifdef M16_BIT_STICKY_OVF_EN
    m_sticky = 1'b0;
`endif
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_sum"},   32'(add_out),   32'(m_sum));
    chk({tag, "_valid"}, 32'(out_valid), 32'(m_valid));
    chk({tag, "_pos"},   32'(sat_pos),   32'(m_pos));
    chk({tag, "_neg"},   32'(sat_neg),   32'(m_neg));
`ifdef M16_BIT_STICKY_OVF_EN
    chk({tag, "_sticky"}, 32'(ovf_sticky), 32'(m_sticky));
`endif
  endtask

  task automatic cycle(input logic v, input logic [15:0] x, input logic [15:0] y,
                       input logic clr, input string tag);
    logic [15:0] s;
    logic        p;
    logic        n;
    @(negedge clk);
    in_valid = v;
    a        = x;
    b        = y;
`ifdef M16_BIT_STICKY_OVF_EN
    ovf_clr  = clr;
`endif
    @(posedge clk);
    ref_add(x, y, s, p, n);
    if (v) begin
      m_sum = s;
      m_pos = p;
      m_neg = n;
    end
    m_valid = v;
`ifdef M16_BIT_STICKY_OVF_EN
    if (v && (p || n)) m_sticky = 1'b1;
    else if (clr)      m_sticky = 1'b0;
`else
    if (clr) m_valid = v;
`endif
    #1;
    check_all(tag);
  endtask

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 3))
      0:       pick = 16'($urandom);
      1:       pick = 16'h7F00 + 16'($urandom_range(0, 255));
      2:       pick = 16'h8000 + 16'($urandom_range(0, 255));
      default: pick = 16'($urandom_range(0, 64)) - 16'd32;
    endcase
  endfunction

  vec_t vecs[10];

  initial begin
    total = 0;
    bad   = 0;
    vecs[0] = '{16'd1000, 16'd2000, 16'h0BB8, 1'b0, 1'b0};
    vecs[1] = '{16'h7FFF, 16'h0001, 16'h7FFF, 1'b1, 1'b0};
    vecs[2] = '{16'h8000, 16'hFFFF, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{16'h8000, 16'h0000, 16'h8000, 1'b0, 1'b0};
    vecs[4] = '{16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0};
    vecs[5] = '{16'h8000, 16'h7FFF, 16'hFFFF, 1'b0, 1'b0};
    vecs[6] = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b1, 1'b0};
    vecs[7] = '{16'h8000, 16'h8000, 16'h8000, 1'b0, 1'b1};
    vecs[8] = '{16'hFFFF, 16'h0001, 16'h0000, 1'b0, 1'b0};
    vecs[9] = '{16'h4000, 16'h4000, 16'h7FFF, 1'b1, 1'b0};

    // Reset held with live random traffic.
    rst_n    = 1'b0;
    in_valid = 1'b1;
    a        = 16'($urandom);
    b        = 16'($urandom);
`ifdef M16_BIT_STICKY_OVF_EN
    ovf_clr  = 1'b0;
`endif
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      a = 16'h7FFF;
      b = 16'($urandom);
      #1;
      check_all("rst_hold");
    end

    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    cycle(1'b0, 16'd5, 16'd6, 1'b0, "post_rst_idle");
    cycle(1'b1, 16'd5, 16'd6, 1'b0, "post_rst_first");
    chk("post_rst_first_const", 32'(add_out), 32'd11);

    foreach (vecs[i]) begin
      cycle(1'b1, vecs[i].a, vecs[i].b, 1'b0, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d_tsum", i), 32'(add_out), 32'(vecs[i].sum));
      chk($sformatf("vec%0d_tpos", i), 32'(sat_pos), 32'(vecs[i].pos));
      chk($sformatf("vec%0d_tneg", i), 32'(sat_neg), 32'(vecs[i].neg));
    end

    // Back-to-back then idle: valid drops while result and flags hold.
    cycle(1'b1, 16'd10, 16'd20, 1'b0, "b2b0");
    cycle(1'b1, 16'h7000, 16'h2000, 1'b0, "b2b1");
    cycle(1'b1, 16'hFFF0, 16'h0001, 1'b0, "b2b2");
    cycle(1'b1, 16'h9000, 16'h9000, 1'b0, "b2b3");
    cycle(1'b0, 16'd1, 16'd1, 1'b0, "idle0");
    cycle(1'b0, 16'h7FFF, 16'h7FFF, 1'b0, "idle1");
    chk("idle_hold_sum", 32'(add_out), 32'h8000);
    chk("idle_hold_neg", 32'(sat_neg), 32'd1);
    chk("idle_valid", 32'(out_valid), 32'd0);

`ifdef M16_BIT_STICKY_OVF_EN
    cycle(1'b1, 16'h7FFF, 16'h0010, 1'b0, "stk_set");
    cycle(1'b1, 16'd3, 16'd4, 1'b0, "stk_h0");
    cycle(1'b1, 16'd7, 16'hFFFF, 1'b0, "stk_h1");
    chk("stk_hold_const", 32'(ovf_sticky), 32'd1);
    cycle(1'b0, 16'd0, 16'd0, 1'b1, "stk_clr");
    chk("stk_clr_const", 32'(ovf_sticky), 32'd0);
    cycle(1'b1, 16'h8000, 16'h8001, 1'b1, "stk_setwins");
    chk("stk_setwins_const", 32'(ovf_sticky), 32'd1);
`endif

    // Asynchronous reset between edges discards the registered result.
    cycle(1'b1, 16'h7FFF, 16'h0100, 1'b0, "pre_async");
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    cycle(1'b0, 16'd0, 16'd0, 1'b0, "async_idle");
    cycle(1'b1, 16'd100, 16'hFF9C, 1'b0, "async_first");

    for (int i = 0; i < 300; i++) begin
      cycle(logic'($urandom_range(0, 3) != 0), pick(), pick(),
            logic'($urandom_range(0, 7) == 0), "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
